// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Self-invalidates after reset by sweeping every entry before accepting traffic.
module branch_target_buffer #(
   parameter int ENTRY_NUM     = 1024,
   parameter int TAG_WIDTH     = 4,
   parameter int CONTENT_WIDTH = 13,
   parameter int PC_WIDTH      = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                ready,
   input  logic                lookupValid,
   input  logic [PC_WIDTH-1:0] lookupPC,
   output logic                predictValid,
   output logic                isBranchTakenPredicted,
   output logic                isNextPcPredicted,
   output logic [PC_WIDTH-1:0] predictedNextPC,
   input  logic                updateValid,
   input  logic [PC_WIDTH-1:0] updatePC,
   input  logic                updateTaken,
   input  logic [PC_WIDTH-1:0] updateTarget
);
   localparam int IDX_W = $clog2(ENTRY_NUM);
   localparam int TAG_LO = IDX_W + 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRY_NUM - 1);

   typedef struct packed {
      logic                     valid;
      logic [TAG_WIDTH-1:0]     tag;
      logic [CONTENT_WIDTH-1:0] content;
      logic [1:0]               ctr;
   } entry_t;

   typedef enum logic {INIT, READY} state_t;

   entry_t mem [ENTRY_NUM];

   state_t             state;
   logic [IDX_W-1:0]   sweep_idx;
   logic               pred_valid;
   entry_t             entry_reg;
   logic [PC_WIDTH-1:0] pc_reg;

   // Sweep FSM: clears one entry per cycle, then stays READY until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         sweep_idx <= '0;
         ready     <= 1'b0;
      end else if (state == INIT) begin
         sweep_idx <= sweep_idx + 1'b1;
         if (sweep_idx == LAST_IDX) begin
            state <= READY;
            ready <= 1'b1;
         end
      end
   end

   // Update path: combinational read of the indexed entry, write at the edge.
   logic [IDX_W-1:0]     upd_idx;
   logic [TAG_WIDTH-1:0] upd_tag;
   entry_t               upd_entry;
   logic                 upd_hit;
   logic                 wr_en;
   logic [IDX_W-1:0]     wr_idx;
   entry_t               wr_data;

   assign upd_idx   = updatePC[TAG_LO-1:2];
   assign upd_tag   = updatePC[TAG_LO+TAG_WIDTH-1:TAG_LO];
   assign upd_entry = mem[upd_idx];
   assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

   always_comb begin
      wr_en           = 1'b0;
      wr_idx          = upd_idx;
      wr_data         = upd_entry;
      wr_data.valid   = 1'b1;
      wr_data.tag     = upd_tag;
      if (state == INIT) begin
         wr_en   = 1'b1;
         wr_idx  = sweep_idx;
         wr_data = '{valid: 1'b0, tag: '0, content: '0, ctr: 2'b01};
      end else if (updateValid) begin
         if (upd_hit && updateTaken) begin
            wr_en           = 1'b1;
            wr_data.content = updateTarget[CONTENT_WIDTH+1:2];
            if (upd_entry.ctr != 2'b11)
               wr_data.ctr = upd_entry.ctr + 2'b01;
         end else if (upd_hit) begin
            wr_en = 1'b1;
            if (upd_entry.ctr != 2'b00)
               wr_data.ctr = upd_entry.ctr - 2'b01;
         end else if (updateTaken) begin
            wr_en           = 1'b1;
            wr_data.content = updateTarget[CONTENT_WIDTH+1:2];
            wr_data.ctr     = 2'b10;
         end
      end
   end

   // The lookup read shares the edge with the write, so it sees the old entry.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= wr_data;
      entry_reg <= mem[lookupPC[TAG_LO-1:2]];
      pc_reg    <= lookupPC;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pred_valid <= 1'b0;
      else
         pred_valid <= lookupValid && (state == READY);
   end

   logic hit;
   logic taken;

   assign hit   = pred_valid && entry_reg.valid &&
                  (entry_reg.tag == pc_reg[TAG_LO+TAG_WIDTH-1:TAG_LO]);
   assign taken = hit && entry_reg.ctr[1];

   assign predictValid           = pred_valid;
   assign isNextPcPredicted      = hit;
   assign isBranchTakenPredicted = taken;

   always_comb begin
      predictedNextPC = '0;
      if (taken)
         predictedNextPC = {pc_reg[PC_WIDTH-1:CONTENT_WIDTH+2], entry_reg.content, 2'b00};
      else if (pred_valid)
         predictedNextPC = pc_reg + PC_WIDTH'(4);
   end

   // Only the fields above are meaningful; the rest of these buses is ignored.
   logic unused_bits;
   assign unused_bits = ^{updatePC[PC_WIDTH-1:TAG_LO+TAG_WIDTH], updatePC[1:0],
                          updateTarget[PC_WIDTH-1:CONTENT_WIDTH+2], updateTarget[1:0]};
endmodule
